// File: rtl/snake_pkg.sv
// Shared snake-game types: movement directions, request FSM states, debounce defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snake_pkg;

  // Direction encoding shared with the navigation state machine.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  // Turn-request holder: nothing held, or exactly one request held.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } req_state_e;

  // 5 ms at 100 MHz; the counter width must hold DEBOUNCE_DEFAULT-1.
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT    = 19;

  // One-hot button vector indexed by direction: bit0=T, bit1=R, bit2=D, bit3=L.
  function automatic logic [3:0] dir_onehot(input dir_e d);
    dir_onehot = 4'b0001 << d;
  endfunction

endpackage

// File: rtl/button_turn_conditioner_if.sv
// Raw button inputs, movement tick and conditioned button pulses of the turn conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or single-cycle pulses.
interface button_turn_conditioner_if;
  logic BTNL_IN;
  logic BTNT_IN;
  logic BTNR_IN;
  logic BTND_IN;
  logic TICK;
  logic BTNL;
  logic BTNT;
  logic BTNR;
  logic BTND;
  logic PENDING;

  // Board / timer side: drives raw buttons and the tick, consumes the pulses.
  modport master (
    output BTNL_IN, BTNT_IN, BTNR_IN, BTND_IN, TICK,
    input  BTNL, BTNT, BTNR, BTND, PENDING
  );

  // Conditioner side.
  modport slave (
    input  BTNL_IN, BTNT_IN, BTNR_IN, BTND_IN, TICK,
    output BTNL, BTNT, BTNR, BTND, PENDING
  );
endinterface

// File: rtl/button_debouncer.sv
// One button: 2-FF synchroniser, stable-count debouncer, rising-edge press detect.
// Latency: press is high DEBOUNCE_CYCLES+1 edges after the raw level is first sampled.
// Backpressure: none; the press pulse is a one-cycle strobe.
module button_debouncer
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_raw,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_db_d;

  // Synchronise the asynchronous button and track how long it has differed from db.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Differed for DEBOUNCE_CYCLES consecutive cycles: accept the new level.
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Only a debounced rising edge counts; releases are ignored.
  assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/button_turn_conditioner.sv
// Debounces four buttons, holds one turn request, releases it as a button pulse per movement tick.
// Latency: PENDING rises DEBOUNCE_CYCLES+2 edges after raw press; pulse is high the cycle after TICK.
// Backpressure: none; a press arriving while a request is held (without TICK) is dropped.
module button_turn_conditioner
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input logic                       CLK,
  input logic                       RESET,
  button_turn_conditioner_if.slave  bus
);

  logic [3:0] w_press;      // indexed by dir_e: 0=T, 1=R, 2=D, 3=L
  logic       w_press_any;
  dir_e       w_dir;

  req_state_e r_state;
  req_state_e w_state_nxt;
  dir_e       r_dir;
  dir_e       w_dir_nxt;
  logic [3:0] r_pulse;
  logic [3:0] w_pulse_nxt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_t (
    .CLK(CLK), .RESET(RESET), .i_raw(bus.BTNT_IN), .o_press(w_press[0])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_r (
    .CLK(CLK), .RESET(RESET), .i_raw(bus.BTNR_IN), .o_press(w_press[1])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_d (
    .CLK(CLK), .RESET(RESET), .i_raw(bus.BTND_IN), .o_press(w_press[2])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_l (
    .CLK(CLK), .RESET(RESET), .i_raw(bus.BTNL_IN), .o_press(w_press[3])
  );

  // Coincident presses resolve T > R > D > L; only the winner reaches the FSM.
  always_comb begin
    w_press_any = |w_press;
    w_dir       = DIR_UP;
    if (w_press[0])      w_dir = DIR_UP;
    else if (w_press[1]) w_dir = DIR_RIGHT;
    else if (w_press[2]) w_dir = DIR_DOWN;
    else if (w_press[3]) w_dir = DIR_LEFT;
  end

  // Request FSM state, held direction and registered output pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_UP;
      r_pulse <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Next state: capture in IDLE; in HELD release on TICK, re-capturing a same-cycle press.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_pulse_nxt = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        // A press coinciding with TICK is only captured; it waits for the next TICK.
        if (w_press_any) begin
          w_dir_nxt   = w_dir;
          w_state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (bus.TICK) begin
          w_pulse_nxt = dir_onehot(r_dir);
          if (w_press_any) begin
            w_dir_nxt = w_dir;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.BTNT    = r_pulse[0];
  assign bus.BTNR    = r_pulse[1];
  assign bus.BTND    = r_pulse[2];
  assign bus.BTNL    = r_pulse[3];
  assign bus.PENDING = (r_state == ST_HELD);

endmodule
